// File: rtl/srs_pkg.sv
// Shared types and helpers for the stimulus/response sequencer.
package srs_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam int ROT_MAX = 64;

  // Rotate left by one within the low w bits; v must already be zero above bit w-1.
  function automatic logic [ROT_MAX-1:0] rotl1(input logic [ROT_MAX-1:0] v, input int w);
    logic [ROT_MAX-1:0] mask;
    mask = (w >= ROT_MAX) ? '1 : ((ROT_MAX'(1) << w) - ROT_MAX'(1));
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/srs_fifo.sv
// Record buffer: synchronous FIFO that accepts a push into a full buffer when a pop happens in the same cycle.
module srs_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         CK,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge CK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/stim_resp_sequencer.sv
// Walks every IN_W-bit vector, settles, captures the response into a record FIFO and folds it into sig.
//   state     | meaning
//   S_IDLE    | waiting for start after reset
//   S_DRIVE   | present vec on dut_in, load settle timer
//   S_SETTLE  | count down SETTLE cycles
//   S_CAPTURE | push {vec, dut_out}; stall here while the FIFO cannot accept
//   S_DONE    | all vectors captured; start begins a new run
module stim_resp_sequencer
  import srs_pkg::*;
#(
  parameter int IN_W       = 1,
  parameter int OUT_W      = 1,
  parameter int SETTLE     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int SIG_W      = 16
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [IN_W-1:0]  rec_vec,
  output logic [OUT_W-1:0] rec_resp,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IN_W:0] LAST_VEC = (IN_W+1)'((1 << IN_W) - 1);

  typedef struct packed {
    logic [IN_W-1:0]  vec;
    logic [OUT_W-1:0] resp;
  } rec_t;

  state_t         state;
  logic [IN_W:0]  vec;
  logic [CNT_W-1:0] cnt;
  rec_t           wr_rec;
  rec_t           rd_rec;
  logic           push;
  logic           pop;
  logic           push_ok;
  logic           full;
  logic           empty;

  assign wr_rec    = '{vec: vec[IN_W-1:0], resp: dut_out};
  assign push      = (state == S_CAPTURE);
  assign pop       = rec_valid && rec_ready;
  assign push_ok   = !full || pop;
  assign rec_valid = !empty;
  assign rec_vec   = rd_rec.vec;
  assign rec_resp  = rd_rec.resp;

  srs_fifo #(
    .W    (IN_W + OUT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CK   (CK),
    .reset(reset),
    .push (push),
    .din  (wr_rec),
    .pop  (pop),
    .dout (rd_rec),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge CK) begin
    if (reset) begin
      state  <= S_IDLE;
      dut_in <= '0;
      vec    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sig    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec   <= '0;
            sig   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          dut_in <= vec[IN_W-1:0];
          cnt    <= CNT_W'(SETTLE - 1);
          state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == '0) state <= S_CAPTURE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        S_CAPTURE: begin
          if (push_ok) begin
            sig <= SIG_W'(rotl1(ROT_MAX'(sig), SIG_W)) ^ SIG_W'(dut_out);
            if (vec == LAST_VEC) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              vec   <= vec + (IN_W+1)'(1);
              state <= S_DRIVE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stim_resp_sequencer.sv
// Bench: inverter instance checked from a cycle table, 3-bit instance checked against a record/signature model.
module tb_stim_resp_sequencer;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bstep();
    @(posedge CK);
    #1;
  endtask

  // ---------------- instance A: IN_W=1 inverter, SETTLE=1
  logic        reset_a, start_a, ready_a, valid_a, busy_a, done_a;
  logic [0:0]  in_a, out_a, vec_a, resp_a;
  logic [15:0] sig_a;
  assign out_a = ~in_a;

  stim_resp_sequencer #(.IN_W(1), .OUT_W(1), .SETTLE(1), .FIFO_DEPTH(4), .SIG_W(16)) dut_a (
    .CK(CK), .reset(reset_a), .start(start_a), .dut_in(in_a), .dut_out(out_a),
    .rec_valid(valid_a), .rec_ready(ready_a), .rec_vec(vec_a), .rec_resp(resp_a),
    .busy(busy_a), .done(done_a), .sig(sig_a)
  );

  // ---------------- instance B: IN_W=3, OUT_W=3, SETTLE=3, 4-deep FIFO
  logic        reset_b, start_b, ready_b, valid_b, busy_b, done_b;
  logic [2:0]  in_b, out_b, vec_b, resp_b;
  logic [15:0] sig_b;
  logic [2:0]  lut [8];
  always_comb out_b = lut[in_b];

  stim_resp_sequencer #(.IN_W(3), .OUT_W(3), .SETTLE(3), .FIFO_DEPTH(4), .SIG_W(16)) dut_b (
    .CK(CK), .reset(reset_b), .start(start_b), .dut_in(in_b), .dut_out(out_b),
    .rec_valid(valid_b), .rec_ready(ready_b), .rec_vec(vec_b), .rec_resp(resp_b),
    .busy(busy_b), .done(done_b), .sig(sig_b)
  );

  // Model: a run yields records (v, lut[v]) for v = 0..7 in order; sig folds them with rotate-xor.
  logic [5:0]  exp_q [$];
  logic [15:0] exp_sig;

  task automatic load_expect();
    logic [15:0] s;
    exp_q.delete();
    s = 16'h0;
    for (int v = 0; v < 8; v++) begin
      exp_q.push_back({3'(v), lut[v]});
      s = {s[14:0], s[15]} ^ {13'h0, lut[v]};
    end
    exp_sig = s;
  endtask

  // Inputs change 1 time unit after posedge, so values seen here are what the next edge samples.
  always @(negedge CK) begin
    if (!reset_b && valid_b && ready_b) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rec_extra: got record %0h, required none", {vec_b, resp_b});
      end else begin
        check("rec_b", 64'({vec_b, resp_b}), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic pulse_start_b();
    start_b = 1'b1;
    bstep();
    start_b = 1'b0;
  endtask

  task automatic wait_done_b(input string name, input bit rand_ready);
    int n = 0;
    while (!done_b && n < 2000) begin
      if (rand_ready) ready_b = 1'($urandom_range(0, 1));
      bstep();
      n++;
    end
    check(name, 64'(done_b), 64'(1));
    ready_b = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) bstep();
    bstep();
    check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
    check({name, "_sig"}, 64'(sig_b), 64'(exp_sig));
    check({name, "_last_in"}, 64'(in_b), 64'(7));
  endtask

  // ---------------- cycle table for instance A
  typedef struct {
    logic        st, rd;
    logic        din, valid, vec, resp, busy, done;
    logic [15:0] sig;
  } row_t;

  row_t tbl [16];

  function automatic row_t mk(logic st, logic rd, logic din, logic valid, logic vec,
                              logic resp, logic busy, logic done, logic [15:0] sig);
    row_t r;
    r.st = st; r.rd = rd; r.din = din; r.valid = valid; r.vec = vec;
    r.resp = resp; r.busy = busy; r.done = done; r.sig = sig;
    return r;
  endfunction

  initial begin
    //            st rd  din val vec rsp busy done sig
    tbl[0]  = mk(1, 1,  0,  0,  0,  0,  1,   0,   16'h0); // start -> DRIVE
    tbl[1]  = mk(0, 1,  0,  0,  0,  0,  1,   0,   16'h0);
    tbl[2]  = mk(0, 1,  0,  0,  0,  0,  1,   0,   16'h0);
    tbl[3]  = mk(0, 1,  0,  1,  0,  1,  1,   0,   16'h1); // capture (0,1)
    tbl[4]  = mk(0, 1,  1,  0,  0,  0,  1,   0,   16'h1);
    tbl[5]  = mk(0, 1,  1,  0,  0,  0,  1,   0,   16'h1);
    tbl[6]  = mk(0, 1,  1,  1,  1,  0,  0,   1,   16'h2); // capture (1,0), done
    tbl[7]  = mk(0, 1,  1,  0,  0,  0,  0,   1,   16'h2);
    tbl[8]  = mk(1, 1,  1,  0,  0,  0,  1,   0,   16'h0); // restart from DONE
    tbl[9]  = mk(1, 1,  0,  0,  0,  0,  1,   0,   16'h0); // start while busy ignored
    tbl[10] = mk(0, 1,  0,  0,  0,  0,  1,   0,   16'h0);
    tbl[11] = mk(0, 0,  0,  1,  0,  1,  1,   0,   16'h1);
    tbl[12] = mk(0, 0,  1,  1,  0,  1,  1,   0,   16'h1); // record held
    tbl[13] = mk(0, 1,  1,  0,  0,  0,  1,   0,   16'h1);
    tbl[14] = mk(0, 1,  1,  1,  1,  0,  0,   1,   16'h2);
    tbl[15] = mk(0, 1,  1,  0,  0,  0,  0,   1,   16'h2);

    reset_a = 1'b1; start_a = 1'b0; ready_a = 1'b1;
    reset_b = 1'b1; start_b = 1'b0; ready_b = 1'b1;
    for (int v = 0; v < 8; v++) lut[v] = 3'(v);
    bstep();
    bstep();
    check("rst_a_busy",  64'(busy_a),  64'(0));
    check("rst_a_done",  64'(done_a),  64'(0));
    check("rst_a_valid", 64'(valid_a), 64'(0));
    check("rst_a_in",    64'(in_a),    64'(0));
    check("rst_a_sig",   64'(sig_a),   64'(0));
    check("rst_b_busy",  64'(busy_b),  64'(0));
    check("rst_b_valid", 64'(valid_b), 64'(0));
    reset_a = 1'b0;
    reset_b = 1'b0;
    bstep();

    for (int i = 0; i < 16; i++) begin
      start_a = tbl[i].st;
      ready_a = tbl[i].rd;
      bstep();
      check($sformatf("a_in[%0d]", i),    64'(in_a),    64'(tbl[i].din));
      check($sformatf("a_valid[%0d]", i), 64'(valid_a), 64'(tbl[i].valid));
      if (tbl[i].valid) begin
        check($sformatf("a_vec[%0d]", i),  64'(vec_a),  64'(tbl[i].vec));
        check($sformatf("a_resp[%0d]", i), 64'(resp_a), 64'(tbl[i].resp));
      end
      check($sformatf("a_busy[%0d]", i), 64'(busy_a), 64'(tbl[i].busy));
      check($sformatf("a_done[%0d]", i), 64'(done_a), 64'(tbl[i].done));
      check($sformatf("a_sig[%0d]", i),  64'(sig_a),  64'(tbl[i].sig));
    end
    start_a = 1'b0;

    // Randomised responses and backpressure.
    for (int r = 0; r < 3; r++) begin
      for (int v = 0; v < 8; v++) lut[v] = 3'($urandom);
      load_expect();
      pulse_start_b();
      wait_done_b($sformatf("rand_run%0d", r), 1'b1);
    end

    // Cycle-exact timing, no backpressure, with an ignored start mid-run.
    for (int v = 0; v < 8; v++) lut[v] = 3'($urandom);
    load_expect();
    ready_b = 1'b1;
    pulse_start_b();
    check("t_sig_cleared", 64'(sig_b),  64'(0));
    check("t_busy0",       64'(busy_b), 64'(1));
    check("t_done0",       64'(done_b), 64'(0));
    for (int k = 1; k <= 41; k++) begin
      start_b = (k == 12);
      bstep();
      check($sformatf("t_in[%0d]", k),    64'(in_b),    64'(((k - 1) / 5 > 7) ? 7 : (k - 1) / 5));
      check($sformatf("t_busy[%0d]", k),  64'(busy_b),  64'(k < 40));
      check($sformatf("t_done[%0d]", k),  64'(done_b),  64'(k >= 40));
      check($sformatf("t_valid[%0d]", k), 64'(valid_b), 64'(k >= 5 && k <= 40 && k % 5 == 0));
    end
    start_b = 1'b0;
    check("t_sig", 64'(sig_b), 64'(exp_sig));
    check("t_drained", 64'(exp_q.size()), 64'(0));

    // Full FIFO stall, then a push and pop in the same cycle.
    for (int v = 0; v < 8; v++) lut[v] = 3'(v);
    load_expect();
    ready_b = 1'b0;
    pulse_start_b();
    repeat (45) bstep();
    check("stall_in",    64'(in_b),    64'(4));
    check("stall_busy",  64'(busy_b),  64'(1));
    check("stall_done",  64'(done_b),  64'(0));
    check("stall_valid", 64'(valid_b), 64'(1));
    check("stall_head",  64'(vec_b),   64'(0));
    ready_b = 1'b1;
    bstep();
    check("pp_busy", 64'(busy_b), 64'(1));
    check("pp_in4",  64'(in_b),   64'(4));
    bstep();
    check("pp_in5",  64'(in_b),   64'(5));
    wait_done_b("stall_run", 1'b0);

    // Reset during SETTLE of vector 2 with records still buffered.
    for (int v = 0; v < 8; v++) lut[v] = 3'($urandom);
    load_expect();
    ready_b = 1'b0;
    pulse_start_b();
    repeat (12) bstep();
    check("pre_rst_in",    64'(in_b),    64'(2));
    check("pre_rst_valid", 64'(valid_b), 64'(1));
    reset_b = 1'b1;
    bstep();
    exp_q.delete();
    check("mid_rst_busy",  64'(busy_b),  64'(0));
    check("mid_rst_done",  64'(done_b),  64'(0));
    check("mid_rst_valid", 64'(valid_b), 64'(0));
    check("mid_rst_in",    64'(in_b),    64'(0));
    check("mid_rst_sig",   64'(sig_b),   64'(0));
    reset_b = 1'b0;
    ready_b = 1'b1;
    bstep();
    load_expect();
    pulse_start_b();
    wait_done_b("after_rst_run", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
